// File: rtl/morse_pkg.sv
// Shared types and the ASCII-to-Morse lookup for the Morse keyer.
// Optional sidetone (MORSE_KEYER_SIDETONE_EN) needs nothing from this package.
package morse_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StMark  = 3'd2,
      StSpace = 3'd3,
      StCgap  = 3'd4,
      StWgap  = 3'd5
   } state_e;

   // Pattern is left-justified: the first element sits in bit 5, 1 = dash.
   typedef struct packed {
      logic [2:0] count;
      logic [5:0] pattern;
   } code_t;

   typedef struct packed {
      logic  valid;
      logic  space;
      code_t code;
   } lookup_t;

   // Lengths in dot units.
   localparam logic [2:0] DASH = 3'd3;
   localparam logic [2:0] CGAP = 3'd3;
   localparam logic [2:0] WGAP = 3'd4;

   function automatic lookup_t morse_lookup(input logic [7:0] c);
      logic [7:0] u;
      lookup_t    r;
      u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
      r.valid = 1'b1;
      r.space = 1'b0;
      r.code  = '0;
      case (u)
         8'h20: r.space = 1'b1;
         "A": r.code = '{3'd2, 6'b010000};
         "B": r.code = '{3'd4, 6'b100000};
         "C": r.code = '{3'd4, 6'b101000};
         "D": r.code = '{3'd3, 6'b100000};
         "E": r.code = '{3'd1, 6'b000000};
         "F": r.code = '{3'd4, 6'b001000};
         "G": r.code = '{3'd3, 6'b110000};
         "H": r.code = '{3'd4, 6'b000000};
         "I": r.code = '{3'd2, 6'b000000};
         "J": r.code = '{3'd4, 6'b011100};
         "K": r.code = '{3'd3, 6'b101000};
         "L": r.code = '{3'd4, 6'b010000};
         "M": r.code = '{3'd2, 6'b110000};
         "N": r.code = '{3'd2, 6'b100000};
         "O": r.code = '{3'd3, 6'b111000};
         "P": r.code = '{3'd4, 6'b011000};
         "Q": r.code = '{3'd4, 6'b110100};
         "R": r.code = '{3'd3, 6'b010000};
         "S": r.code = '{3'd3, 6'b000000};
         "T": r.code = '{3'd1, 6'b100000};
         "U": r.code = '{3'd3, 6'b001000};
         "V": r.code = '{3'd4, 6'b000100};
         "W": r.code = '{3'd3, 6'b011000};
         "X": r.code = '{3'd4, 6'b100100};
         "Y": r.code = '{3'd4, 6'b101100};
         "Z": r.code = '{3'd4, 6'b110000};
         "0": r.code = '{3'd5, 6'b111110};
         "1": r.code = '{3'd5, 6'b011110};
         "2": r.code = '{3'd5, 6'b001110};
         "3": r.code = '{3'd5, 6'b000110};
         "4": r.code = '{3'd5, 6'b000010};
         "5": r.code = '{3'd5, 6'b000000};
         "6": r.code = '{3'd5, 6'b100000};
         "7": r.code = '{3'd5, 6'b110000};
         "8": r.code = '{3'd5, 6'b111000};
         "9": r.code = '{3'd5, 6'b111100};
         ".": r.code = '{3'd6, 6'b010101};
         ",": r.code = '{3'd6, 6'b110011};
         "?": r.code = '{3'd6, 6'b001100};
         "/": r.code = '{3'd5, 6'b100100};
         "=": r.code = '{3'd5, 6'b100010};
         "-": r.code = '{3'd6, 6'b100001};
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with async active-low reset; a push into a full FIFO is ignored.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       arst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == LW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign level_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Pointer and occupancy update; power-of-two depth makes pointers wrap naturally.
   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + LW'(1);
         2'b01:   count_d = count_q - LW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/morse_keyer.sv
// Morse transmitter: ASCII bytes in via a FIFO, ITU-timed keying out.
// Define MORSE_KEYER_SIDETONE_EN to add the tone_out square-wave output.
module morse_keyer
   import morse_pkg::*;
#(
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned UNIT_W   = 24,
   parameter int unsigned TONE_DIV = 500
) (
   input  logic                       clk,
   input  logic                       arst_n,
   input  logic                       in_valid,
   input  logic [7:0]                 in_data,
   output logic                       in_ready,
   input  logic [UNIT_W-1:0]          unit_len,
   input  logic                       enable,
   output logic                       key_out,
   output logic                       busy,
   output logic                       dropped,
`ifdef MORSE_KEYER_SIDETONE_EN
   output logic                       tone_out,
`endif
   output logic [$clog2(DEPTH+1)-1:0] level
);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TONE_DIV < 1) begin : g_bad_param
      $error("morse_keyer: DEPTH must be a power of two >= 2 and TONE_DIV >= 1");
   end

   state_e            state_q, state_d;
   logic [7:0]        char_q, char_d;
   logic [UNIT_W-1:0] unit_q, unit_d;
   logic [UNIT_W-1:0] cyc_q, cyc_d;
   logic [2:0]        units_q, units_d;
   logic [2:0]        elems_q, elems_d;
   logic [5:0]        pat_q, pat_d;
   logic              key_q, busy_q, dropped_q;

   logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [7:0]        fifo_rdata;
   lookup_t           lk;
   logic [2:0]        unit_target;
   logic              unit_end, phase_end;

   assign in_ready  = !fifo_full;
   assign fifo_push = in_valid && in_ready;
   assign fifo_pop  = (state_q == StIdle) && enable && !fifo_empty;

   sync_fifo #(
      .WIDTH(8),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .arst_n (arst_n),
      .push_i (fifo_push),
      .pop_i  (fifo_pop),
      .wdata_i(in_data),
      .rdata_o(fifo_rdata),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .level_o(level)
   );

   assign lk = morse_lookup(char_q);

   // Number of dot units the current timed state lasts.
   always_comb begin
      unit_target = 3'd1;
      case (state_q)
         StMark:  unit_target = pat_q[5] ? DASH : 3'd1;
         StCgap:  unit_target = CGAP;
         StWgap:  unit_target = WGAP;
         default: unit_target = 3'd1;
      endcase
   end

   assign unit_end  = (cyc_q == unit_q - UNIT_W'(1));
   assign phase_end = unit_end && (units_q == unit_target - 3'd1);

   // Next-state logic: pop, decode, then walk elements and gaps in unit steps.
   always_comb begin
      state_d = state_q;
      char_d  = char_q;
      unit_d  = unit_q;
      cyc_d   = cyc_q;
      units_d = units_q;
      elems_d = elems_q;
      pat_d   = pat_q;
      case (state_q)
         StIdle: begin
            if (fifo_pop) begin
               char_d  = fifo_rdata;
               state_d = StLoad;
            end
         end
         StLoad: begin
            // unit_q is frozen here for the whole character and its gap.
            unit_d  = (unit_len == '0) ? UNIT_W'(1) : unit_len;
            cyc_d   = '0;
            units_d = '0;
            elems_d = lk.code.count;
            pat_d   = lk.code.pattern;
            if (!lk.valid) begin
               state_d = StIdle;
            end else if (lk.space) begin
               state_d = StWgap;
            end else begin
               state_d = StMark;
            end
         end
         default: begin
            if (unit_end) begin
               cyc_d   = '0;
               units_d = phase_end ? 3'd0 : units_q + 3'd1;
            end else begin
               cyc_d = cyc_q + UNIT_W'(1);
            end
            if (phase_end) begin
               case (state_q)
                  StMark: begin
                     elems_d = elems_q - 3'd1;
                     pat_d   = {pat_q[4:0], 1'b0};
                     state_d = (elems_q > 3'd1) ? StSpace : StCgap;
                  end
                  StSpace: state_d = StMark;
                  default: state_d = StIdle;
               endcase
            end
         end
      endcase
   end

   // FSM/datapath registers; outputs lag the state by one cycle.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= StIdle;
         char_q    <= '0;
         unit_q    <= UNIT_W'(1);
         cyc_q     <= '0;
         units_q   <= '0;
         elems_q   <= '0;
         pat_q     <= '0;
         key_q     <= 1'b0;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         char_q    <= char_d;
         unit_q    <= unit_d;
         cyc_q     <= cyc_d;
         units_q   <= units_d;
         elems_q   <= elems_d;
         pat_q     <= pat_d;
         key_q     <= (state_q == StMark);
         busy_q    <= (state_q != StIdle) || !fifo_empty;
         dropped_q <= (state_q == StLoad) && !lk.valid;
      end
   end

   assign key_out = key_q;
   assign busy    = busy_q;
   assign dropped = dropped_q;

`ifdef MORSE_KEYER_SIDETONE_EN
   localparam int unsigned TW = $clog2(TONE_DIV + 1);

   logic [TW-1:0] div_q, div_d;
   logic          tone_q, tone_d;

   // Sidetone divider runs only while keyed; held cleared otherwise.
   always_comb begin
      div_d  = div_q;
      tone_d = tone_q;
      if (!key_q) begin
         div_d  = '0;
         tone_d = 1'b0;
      end else if (div_q == TW'(TONE_DIV - 1)) begin
         div_d  = '0;
         tone_d = !tone_q;
      end else begin
         div_d = div_q + TW'(1);
      end
   end

   // Sidetone registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         div_q  <= '0;
         tone_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         tone_q <= tone_d;
      end
   end

   assign tone_out = tone_q;
`endif

endmodule
